// File: rtl/pc_seq_ctrl.sv
// Multi-cycle PC sequencing controller: FETCH/DECODE/EXEC with a two-cycle exception entry.
// Optional EXC_COUNT_EN macro adds a saturating 8-bit exception counter output exc_cnt.
module pc_seq_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic       mem_ready,
   input  logic [2:0] op_kind,
   input  logic       br_taken,
   input  logic       ovf,
   input  logic       bad_op,
   output logic [2:0] muxFlag,
   output logic       pcWrite,
   output logic       irWrite,
   output logic       epcWrite,
   output logic       causeWrite,
   output logic [1:0] cause,
   output logic       busy
`ifdef EXC_COUNT_EN
   ,
   output logic [7:0] exc_cnt
`endif
);

   localparam int unsigned MUX_W   = 3;
   localparam int unsigned CAUSE_W = 2;
   localparam int unsigned CNT_W   = 8;

   localparam logic [MUX_W-1:0] MUX_PC4  = MUX_W'(0);
   localparam logic [MUX_W-1:0] MUX_BR   = MUX_W'(1);
   localparam logic [MUX_W-1:0] MUX_JMP  = MUX_W'(2);
   localparam logic [MUX_W-1:0] MUX_EPC  = MUX_W'(3);
   localparam logic [MUX_W-1:0] MUX_EVEC = MUX_W'(4);

   localparam logic [CAUSE_W-1:0] CAUSE_NONE = CAUSE_W'(0);
   localparam logic [CAUSE_W-1:0] CAUSE_OVF  = CAUSE_W'(1);
   localparam logic [CAUSE_W-1:0] CAUSE_ILL  = CAUSE_W'(2);

   typedef enum logic [2:0] {
      S_FETCH    = 3'd0,
      S_DECODE   = 3'd1,
      S_EXEC     = 3'd2,
      S_EXC_SAVE = 3'd3,
      S_EXC_JUMP = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [CAUSE_W-1:0] cause_q, cause_d;
   logic [MUX_W-1:0]   mux_c;
   logic               pc_wr_c, ir_wr_c, epc_wr_c, cause_wr_c;
   logic               illegal_c, exc_enter_c;

   // State and latched cause registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         cause_q <= CAUSE_NONE;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
      end
   end

   // Next-state and strobe decode
   always_comb begin
      state_d     = state_q;
      cause_d     = cause_q;
      mux_c       = MUX_PC4;
      pc_wr_c     = 1'b0;
      ir_wr_c     = 1'b0;
      epc_wr_c    = 1'b0;
      cause_wr_c  = 1'b0;
      exc_enter_c = 1'b0;
      illegal_c   = bad_op | op_kind[2];

      case (state_q)
         S_FETCH: begin
            if (mem_ready) begin
               ir_wr_c = 1'b1;
               pc_wr_c = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            if (illegal_c || ovf) begin
               // Illegal-op outranks overflow when both fire together
               exc_enter_c = 1'b1;
               cause_d     = illegal_c ? CAUSE_ILL : CAUSE_OVF;
               state_d     = S_EXC_SAVE;
            end else begin
               case (op_kind[1:0])
                  2'd1: begin
                     if (br_taken) begin
                        mux_c   = MUX_BR;
                        pc_wr_c = 1'b1;
                     end
                  end
                  2'd2: begin
                     mux_c   = MUX_JMP;
                     pc_wr_c = 1'b1;
                  end
                  2'd3: begin
                     mux_c   = MUX_EPC;
                     pc_wr_c = 1'b1;
                  end
                  default: ;
               endcase
               state_d = S_FETCH;
            end
         end
         S_EXC_SAVE: begin
            epc_wr_c   = 1'b1;
            cause_wr_c = 1'b1;
            state_d    = S_EXC_JUMP;
         end
         S_EXC_JUMP: begin
            mux_c   = MUX_EVEC;
            pc_wr_c = 1'b1;
            state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Reset forces every output quiet, whatever state the FSM is in
   assign muxFlag    = reset ? MUX_PC4 : mux_c;
   assign pcWrite    = ~reset & pc_wr_c;
   assign irWrite    = ~reset & ir_wr_c;
   assign epcWrite   = ~reset & epc_wr_c;
   assign causeWrite = ~reset & cause_wr_c;
   assign cause      = reset ? CAUSE_NONE : cause_q;
   assign busy       = ~reset & (state_q != S_FETCH);

`ifdef EXC_COUNT_EN
   logic [CNT_W-1:0] cnt_q;

   // Saturating count of exception entries
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (exc_enter_c && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign exc_cnt = cnt_q;
`else
   logic unused_exc_enter;
   assign unused_exc_enter = exc_enter_c;
`endif

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Scoreboard bench for pc_seq_ctrl: stimulus queues hand-computed per-cycle outputs, a monitor compares.
// Compile with +define+EXC_COUNT_EN to also check the exception counter.
module tb_pc_seq_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       mem_ready = 1'b0;
   logic [2:0] op_kind = 3'd0;
   logic       br_taken = 1'b0;
   logic       ovf = 1'b0;
   logic       bad_op = 1'b0;
   logic [2:0] muxFlag;
   logic       pcWrite, irWrite, epcWrite, causeWrite, busy;
   logic [1:0] cause;
`ifdef EXC_COUNT_EN
   logic [7:0] exc_cnt;
`endif

   pc_seq_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .mem_ready  (mem_ready),
      .op_kind    (op_kind),
      .br_taken   (br_taken),
      .ovf        (ovf),
      .bad_op     (bad_op),
      .muxFlag    (muxFlag),
      .pcWrite    (pcWrite),
      .irWrite    (irWrite),
      .epcWrite   (epcWrite),
      .causeWrite (causeWrite),
      .cause      (cause),
      .busy       (busy)
`ifdef EXC_COUNT_EN
      ,
      .exc_cnt    (exc_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      string      nm;
      logic [9:0] o;
      logic [7:0] cnt;
      bit         cnt_chk;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   logic [7:0] exp_cnt = 8'd0;
   bit   cnt_known = 1'b0;
   logic prev_rst = 1'b1;
   logic [1:0] c;

   // Output vector layout: {muxFlag, pcWrite, irWrite, epcWrite, causeWrite, cause, busy}
   function automatic logic [9:0] E(input logic [2:0] m, input logic pw, input logic iw,
                                    input logic ew, input logic cw, input logic [1:0] cs,
                                    input logic b);
      return {m, pw, iw, ew, cw, cs, b};
   endfunction

   task automatic cyc(input string nm, input logic r, input logic mr, input logic [2:0] op,
                      input logic bt, input logic ov, input logic bad, input logic [9:0] o,
                      input bit sv);
      exp_t e;
      @(posedge clk);
      #1;
      reset = r; mem_ready = mr; op_kind = op; br_taken = bt; ovf = ov; bad_op = bad;
      if (prev_rst) begin
         exp_cnt   = 8'd0;
         cnt_known = 1'b1;
      end else if (sv && exp_cnt != 8'd255) begin
         exp_cnt = exp_cnt + 8'd1;
      end
      prev_rst = r;
      e.nm = nm; e.o = o; e.cnt = exp_cnt; e.cnt_chk = cnt_known;
      sb.push_back(e);
   endtask

   task automatic fetch(input logic [1:0] cs);
      cyc("fetch", 1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b1, E(3'd0, 1, 1, 0, 0, cs, 0), 1'b0);
   endtask

   // ovf/bad_op/br_taken asserted here must be ignored outside EXEC
   task automatic decode(input logic [1:0] cs);
      cyc("decode", 1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1, E(3'd0, 0, 0, 0, 0, cs, 1), 1'b0);
   endtask

   task automatic exc_seq(input logic [1:0] cs);
      cyc("exc_save", 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b1, E(3'd0, 0, 0, 1, 1, cs, 1), 1'b1);
      cyc("exc_jump", 1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b1, E(3'd4, 1, 0, 0, 0, cs, 1), 1'b0);
   endtask

   // Monitor: every queued expectation is compared on the falling edge of its cycle
   always @(negedge clk) begin
      exp_t e;
      logic [9:0] act;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         act = {muxFlag, pcWrite, irWrite, epcWrite, causeWrite, cause, busy};
         checks++;
         if (act !== e.o) begin
            failures++;
            $display("FAIL %s @%0t: got mux=%0d pcw=%b irw=%b epcw=%b cw=%b cause=%0d busy=%b, want mux=%0d pcw=%b irw=%b epcw=%b cw=%b cause=%0d busy=%b",
                     e.nm, $time, act[9:7], act[6], act[5], act[4], act[3], act[2:1], act[0],
                     e.o[9:7], e.o[6], e.o[5], e.o[4], e.o[3], e.o[2:1], e.o[0]);
         end
`ifdef EXC_COUNT_EN
         if (e.cnt_chk) begin
            checks++;
            if (exc_cnt !== e.cnt) begin
               failures++;
               $display("FAIL %s exc_cnt @%0t: got %0d want %0d", e.nm, $time, exc_cnt, e.cnt);
            end
         end
`endif
      end
   end

   initial begin
      c = 2'd0;
      cyc("reset0", 1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 1'b1, E(3'd0, 0, 0, 0, 0, 2'd0, 0), 1'b0);
      cyc("reset1", 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, E(3'd0, 0, 0, 0, 0, 2'd0, 0), 1'b0);

      // Sequential instruction, back in FETCH at cycle 4
      fetch(c); decode(c);
      cyc("exec_seq", 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, E(3'd0, 0, 0, 0, 0, c, 1), 1'b0);
      cyc("fetch_back", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, E(3'd0, 0, 0, 0, 0, c, 0), 1'b0);

      // Memory stall holds FETCH
      for (int i = 0; i < 5; i++)
         cyc("fetch_hold", 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b1, E(3'd0, 0, 0, 0, 0, c, 0), 1'b0);

      fetch(c); decode(c);
      cyc("exec_br_taken", 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, E(3'd1, 1, 0, 0, 0, c, 1), 1'b0);
      fetch(c); decode(c);
      cyc("exec_br_not", 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, E(3'd0, 0, 0, 0, 0, c, 1), 1'b0);
      fetch(c); decode(c);
      cyc("exec_jump", 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, E(3'd2, 1, 0, 0, 0, c, 1), 1'b0);
      fetch(c); decode(c);
      cyc("exec_rfe", 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, E(3'd3, 1, 0, 0, 0, c, 1), 1'b0);

      // ovf and bad_op together: illegal wins
      fetch(c); decode(c);
      cyc("exec_ill_ovf", 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, E(3'd0, 0, 0, 0, 0, c, 1), 1'b0);
      c = 2'd2; exc_seq(c);
      cyc("idle_after_exc", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, E(3'd0, 0, 0, 0, 0, c, 0), 1'b0);

      // Overflow on a taken branch: no PC write, cause 1
      fetch(c); decode(c);
      cyc("exec_ovf_br", 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, E(3'd0, 0, 0, 0, 0, c, 1), 1'b0);
      c = 2'd1; exc_seq(c);

      // Reserved op_kind with overflow is still illegal
      fetch(c); decode(c);
      cyc("exec_rsvd7", 1'b0, 1'b0, 3'd7, 1'b0, 1'b1, 1'b0, E(3'd0, 0, 0, 0, 0, c, 1), 1'b0);
      c = 2'd2; exc_seq(c);
      fetch(c); decode(c);
      cyc("exec_ovf", 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, E(3'd0, 0, 0, 0, 0, c, 1), 1'b0);
      c = 2'd1; exc_seq(c);
      fetch(c); decode(c);
      cyc("exec_rsvd5", 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, E(3'd0, 0, 0, 0, 0, c, 1), 1'b0);
      c = 2'd2; exc_seq(c);

      // Reset during EXC_SAVE abandons the sequence
      fetch(c); decode(c);
      cyc("exec_ovf_r", 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, E(3'd0, 0, 0, 0, 0, c, 1), 1'b0);
      cyc("rst_in_save", 1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 1'b1, E(3'd0, 0, 0, 0, 0, 2'd0, 0), 1'b1);
      c = 2'd0;
      cyc("after_rst_save", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, E(3'd0, 0, 0, 0, 0, c, 0), 1'b0);

      // Reset during EXC_JUMP
      fetch(c); decode(c);
      cyc("exec_bad", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, E(3'd0, 0, 0, 0, 0, c, 1), 1'b0);
      cyc("exc_save", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, E(3'd0, 0, 0, 1, 1, 2'd2, 1), 1'b1);
      cyc("rst_in_jump", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, E(3'd0, 0, 0, 0, 0, 2'd0, 0), 1'b0);
      cyc("after_rst_jump", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, E(3'd0, 0, 0, 0, 0, c, 0), 1'b0);

      // 300 overflow exceptions: counter saturates at 255
      for (int i = 0; i < 300; i++) begin
         fetch(c); decode(c);
         cyc("exec_ovf_loop", 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, E(3'd0, 0, 0, 0, 0, c, 1), 1'b0);
         c = 2'd1; exc_seq(c);
      end
      cyc("final_idle", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, E(3'd0, 0, 0, 0, 0, c, 0), 1'b0);

      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
